// File: rtl/cycle_ctrl_pkg.sv
// Shared encodings for the machine-cycle controller: state codes, beat
// constants and the one-hot test used to validate the beat ring.
package cycle_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WB    = 2'b11
    } state_e;

    localparam logic [3:0] B0 = 4'b1000;
    localparam logic [3:0] B1 = 4'b0100;
    localparam logic [3:0] B2 = 4'b0010;
    localparam logic [3:0] B3 = 4'b0001;

    // Zero and multi-bit patterns are both rejected.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/beat_check.sv
// Combinational one-hot validity test of the beat vector.
module beat_check
    import cycle_ctrl_pkg::*;
(
    input  logic [3:0] beat_i,
    output logic       valid_o
);

    assign valid_o = is_onehot4(beat_i);

endmodule

// File: rtl/cycle_controller.sv
// Machine-cycle sequencer: steps IDLE/FETCH/EXEC/WB once per beat ring and
// decodes per-beat control strobes, with sticky halt and beat-fault flags.
module cycle_controller
    import cycle_ctrl_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         T,
    input  logic               start,
    input  logic               stop,
    input  logic               step_mode,
    input  logic               halt_req,
    output logic [1:0]         state,
    output logic               mem_rd,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               alu_en,
    output logic               reg_wr,
    output logic               running,
    output logic               halted,
    output logic               beat_err,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1'b1);

    state_e             state_q, state_d;
    logic               start_pend_q, start_pend_d;
    logic               stop_pend_q, stop_pend_d;
    logic               halt_seen_q, halt_seen_d;
    logic               halted_q, halted_d;
    logic               beat_err_q, beat_err_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               beat_ok_s;
    logic               start_eff_s;
    logic               stop_eff_s;
    logic               idle_s;

    beat_check u_beat_check (
        .beat_i  (T),
        .valid_o (beat_ok_s)
    );

    assign idle_s = (state_q == ST_IDLE);

    // Next-state, request bookkeeping and counter update.
    always_comb begin
        state_d      = state_q;
        halted_d     = halted_q;
        beat_err_d   = beat_err_q;
        count_d      = count_q;
        start_eff_s  = start_pend_q;
        stop_eff_s   = stop_pend_q;
        halt_seen_d  = halt_seen_q | ((state_q == ST_EXEC) & halt_req);

        // Stop dominates start; stop only has meaning while an instruction runs.
        if (stop) begin
            start_eff_s = 1'b0;
            stop_eff_s  = stop_pend_q | ~idle_s;
        end else if (start && idle_s) begin
            start_eff_s = 1'b1;
        end else begin
            start_eff_s = start_pend_q;
        end
        start_pend_d = start_eff_s;
        stop_pend_d  = stop_eff_s;

        if (!beat_ok_s) begin
            state_d      = ST_IDLE;
            beat_err_d   = 1'b1;
            start_pend_d = 1'b0;
            stop_pend_d  = 1'b0;
            halt_seen_d  = 1'b0;
        end else if (T == B3) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_eff_s && !halted_q && !beat_err_q) begin
                        state_d      = ST_FETCH;
                        start_pend_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: state_d = ST_EXEC;
                ST_EXEC:  state_d = ST_WB;
                ST_WB: begin
                    count_d     = count_q + CNT_ONE;
                    halt_seen_d = 1'b0;
                    stop_pend_d = 1'b0;
                    if (stop_eff_s || step_mode || halt_seen_q) begin
                        state_d  = ST_IDLE;
                        halted_d = halted_q | halt_seen_q;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            start_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            halt_seen_q  <= 1'b0;
            halted_q     <= 1'b0;
            beat_err_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
            stop_pend_q  <= stop_pend_d;
            halt_seen_q  <= halt_seen_d;
            halted_q     <= halted_d;
            beat_err_q   <= beat_err_d;
            count_q      <= count_d;
        end
    end

    // Strobe decode from registered state and current beat.
    always_comb begin
        mem_rd  = 1'b0;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        alu_en  = 1'b0;
        reg_wr  = 1'b0;
        if (!beat_err_q) begin
            case (state_q)
                ST_FETCH: begin
                    mem_rd  = (T == B0);
                    ir_load = (T == B1);
                    pc_inc  = (T == B2);
                end
                ST_EXEC: alu_en = (T == B1);
                ST_WB:   reg_wr = (T == B1);
                default: mem_rd = 1'b0;
            endcase
        end else begin
            mem_rd = 1'b0;
        end
    end

    assign state       = state_q;
    assign running     = ~idle_s;
    assign halted      = halted_q;
    assign beat_err    = beat_err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_cycle_controller.sv
// Directed bench for cycle_controller: beat ring is driven by the bench, and
// a second instance with a 4-bit counter exercises counter wrap.
module tb_cycle_controller;

    localparam logic [3:0] TB_B0 = 4'b1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  T;
    logic        start, stop, step_mode, halt_req;
    logic [1:0]  state;
    logic        mem_rd, ir_load, pc_inc, alu_en, reg_wr;
    logic        running, halted, beat_err;
    logic [15:0] instr_count;
    logic [1:0]  w4_state;
    logic        w4_mem_rd, w4_ir_load, w4_pc_inc, w4_alu_en, w4_reg_wr;
    logic        w4_running, w4_halted, w4_beat_err;
    logic [3:0]  w4_count;
    logic [4:0]  stb, w4_stb;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_tbl [12] = '{5'b10000, 5'b01000, 5'b00100, 5'b00000,
                                 5'b00000, 5'b00010, 5'b00000, 5'b00000,
                                 5'b00000, 5'b00001, 5'b00000, 5'b00000};

    assign stb    = {mem_rd, ir_load, pc_inc, alu_en, reg_wr};
    assign w4_stb = {w4_mem_rd, w4_ir_load, w4_pc_inc, w4_alu_en, w4_reg_wr};

    always #5 clk = ~clk;

    cycle_controller #(.COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .T(T), .start(start), .stop(stop),
        .step_mode(step_mode), .halt_req(halt_req), .state(state),
        .mem_rd(mem_rd), .ir_load(ir_load), .pc_inc(pc_inc), .alu_en(alu_en),
        .reg_wr(reg_wr), .running(running), .halted(halted),
        .beat_err(beat_err), .instr_count(instr_count)
    );

    cycle_controller #(.COUNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .T(T), .start(start), .stop(stop),
        .step_mode(step_mode), .halt_req(halt_req), .state(w4_state),
        .mem_rd(w4_mem_rd), .ir_load(w4_ir_load), .pc_inc(w4_pc_inc),
        .alu_en(w4_alu_en), .reg_wr(w4_reg_wr), .running(w4_running),
        .halted(w4_halted), .beat_err(w4_beat_err), .instr_count(w4_count)
    );

    // One clock: inputs advance after the edge, outputs settle before checks.
    task automatic step();
        @(posedge clk);
        #1;
        T = {T[0], T[3:1]};
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; halt_req = 1'b0; step_mode = 1'b0;
        T = TB_B0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    // Start pulse on a B0 beat; returns with the DUT at FETCH/B0.
    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
        run(3);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state got %b want 00", state); end
        checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d want 0", instr_count); end
        checks++; if (halted !== 1'b0 || beat_err !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b want 00", halted, beat_err); end
        checks++; if (running !== 1'b0 || stb !== 5'b00000) begin errors++; $display("FAIL rst_outs got %b/%b want 0/00000", running, stb); end
        launch();
        run(5);
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL mid_exec got %b want 10", state); end
        rst = 1'b1;
        #1;
        checks++; if (state !== 2'b00 || running !== 1'b0 || stb !== 5'b00000) begin errors++; $display("FAIL async_rst got %b/%b/%b want 00/0/00000", state, running, stb); end
        do_reset();
        checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL discard_count got %0d want 0", instr_count); end
        run(8);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL need_start got %b want 00", state); end
    endtask

    task automatic test_single_and_stop();
        do_reset();
        launch();
        checks++; if (state !== 2'b01 || running !== 1'b1) begin errors++; $display("FAIL fetch_entry got %b/%b want 01/1", state, running); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (stb !== exp_tbl[i]) begin errors++; $display("FAIL strobe_beat%0d got %b want %b", i, stb, exp_tbl[i]); end
            step();
        end
        checks++; if (instr_count !== 16'd1 || state !== 2'b01) begin errors++; $display("FAIL first_retire got %0d/%b want 1/01", instr_count, state); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        run(3);
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL stop_exec got %b want 10", state); end
        start = 1'b1;
        step();
        start = 1'b0;
        run(3);
        checks++; if (state !== 2'b11 || instr_count !== 16'd1) begin errors++; $display("FAIL stop_wb got %b/%0d want 11/1", state, instr_count); end
        run(4);
        checks++; if (state !== 2'b00 || running !== 1'b0 || instr_count !== 16'd2) begin errors++; $display("FAIL stop_idle got %b/%b/%0d want 00/0/2", state, running, instr_count); end
        run(8);
        checks++; if (state !== 2'b00 || instr_count !== 16'd2) begin errors++; $display("FAIL busy_start got %b/%0d want 00/2", state, instr_count); end
    endtask

    task automatic test_step_mode();
        do_reset();
        step_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            launch();
            run(12);
            checks++; if (state !== 2'b00 || instr_count !== 16'(k + 1)) begin errors++; $display("FAIL step_instr%0d got %b/%0d want 00/%0d", k, state, instr_count, k + 1); end
            run(4);
            checks++; if (state !== 2'b00) begin errors++; $display("FAIL step_hold%0d got %b want 00", k, state); end
        end
        step_mode = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        launch();
        run(5);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        run(2);
        checks++; if (state !== 2'b11 || halted !== 1'b0) begin errors++; $display("FAIL halt_wb got %b/%b want 11/0", state, halted); end
        run(4);
        checks++; if (state !== 2'b00 || halted !== 1'b1 || instr_count !== 16'd1) begin errors++; $display("FAIL halt_idle got %b/%b/%0d want 00/1/1", state, halted, instr_count); end
        launch();
        run(4);
        checks++; if (state !== 2'b00 || instr_count !== 16'd1) begin errors++; $display("FAIL halt_block got %b/%0d want 00/1", state, instr_count); end
        do_reset();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %b want 0", halted); end
        launch();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL halt_restart got %b want 01", state); end
    endtask

    task automatic test_beat_err();
        logic [4:0] seen;
        do_reset();
        launch();
        run(5);
        checks++; if (stb !== 5'b00010) begin errors++; $display("FAIL exec_alu got %b want 00010", stb); end
        @(posedge clk); #1; T = 4'b0110; #1;
        checks++; if (stb !== 5'b00000 || state !== 2'b10) begin errors++; $display("FAIL bad_beat_pre got %b/%b want 00000/10", stb, state); end
        @(posedge clk); #1; T = TB_B0; #1;
        checks++; if (beat_err !== 1'b1 || state !== 2'b00 || running !== 1'b0) begin errors++; $display("FAIL bad_beat got %b/%b/%b want 1/00/0", beat_err, state, running); end
        seen = 5'b00000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            seen = seen | stb;
            step();
        end
        checks++; if (state !== 2'b00 || seen !== 5'b00000 || instr_count !== 16'd0) begin errors++; $display("FAIL err_block got %b/%b/%0d want 00/00000/0", state, seen, instr_count); end
        do_reset();
        checks++; if (beat_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", beat_err); end
    endtask

    task automatic test_start_stop_idle();
        do_reset();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        run(7);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL start_stop_same got %b want 00", state); end
        start = 1'b1;
        step();
        start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        run(6);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL stop_cancels got %b want 00", state); end
        launch();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL idle_stop_clean got %b want 01", state); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        run(11);
        checks++; if (state !== 2'b00 || instr_count !== 16'd1) begin errors++; $display("FAIL idle_stop_end got %b/%0d want 00/1", state, instr_count); end
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        launch();
        run(16 * 12);
        checks++; if (w4_count !== 4'd0 || instr_count !== 16'd16 || w4_state !== 2'b01) begin errors++; $display("FAIL wrap16 got %0d/%0d/%b want 0/16/01", w4_count, instr_count, w4_state); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        run(11);
        checks++; if (w4_count !== 4'd1 || instr_count !== 16'd17) begin errors++; $display("FAIL wrap17 got %0d/%0d want 1/17", w4_count, instr_count); end
        checks++; if (w4_state !== 2'b00 || w4_running !== 1'b0 || w4_halted !== 1'b0 || w4_beat_err !== 1'b0 || w4_stb !== 5'b00000) begin errors++; $display("FAIL w4_idle got %b/%b/%b/%b/%b want 00/0/0/0/00000", w4_state, w4_running, w4_halted, w4_beat_err, w4_stb); end
    endtask

    initial begin
        rst = 1'b1; T = TB_B0; start = 1'b0; stop = 1'b0;
        step_mode = 1'b0; halt_req = 1'b0;
        test_reset();
        test_single_and_stop();
        test_step_mode();
        test_halt();
        test_beat_err();
        test_start_stop_idle();
        test_back_to_back_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
